// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// Pipeline EX stage: operand forwarding from MA/WB, a single-cycle ALU, and a
// registered EX/MA output bundle (address/result, store data, control, rd).
// Optional build macro EXECUTE_MULDIV_EN adds an iterative unsigned multiplier
// (shift-add) and divider (restoring) behind an IDLE/BUSY/DONE FSM that stalls
// the upstream pipeline.  Without the macro, ops 12/13 produce 0 in one cycle
// and o_stall is tied low.
// ---------------------------------------------------------------------------
module execute_stage #(
    parameter int NB_DATA           = 32,
    parameter int NB_ADDR_REGISTERS = 5,
    parameter int NB_CONTROL_MA_WB  = 7
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_clk_en,
    input  logic                         i_valid,
    input  logic [NB_DATA-1:0]           i_rs_data,
    input  logic [NB_DATA-1:0]           i_rt_data,
    input  logic [NB_DATA-1:0]           i_imm,
    input  logic [NB_ADDR_REGISTERS-1:0] i_rs_num,
    input  logic [NB_ADDR_REGISTERS-1:0] i_rt_num,
    input  logic [NB_ADDR_REGISTERS-1:0] i_rd_num,
    input  logic [3:0]                   i_alu_op,
    input  logic                         i_alu_src,
    input  logic [NB_CONTROL_MA_WB-1:0]  i_control_ma_wb,
    input  logic [NB_ADDR_REGISTERS-1:0] i_ma_rd_num,
    input  logic                         i_ma_ctl_reg_write,
    input  logic [NB_DATA-1:0]           i_ma_rd_data,
    input  logic [NB_ADDR_REGISTERS-1:0] i_wb_rd_num,
    input  logic                         i_wb_ctl_reg_write,
    input  logic [NB_DATA-1:0]           i_wb_rd_data,
    output logic [NB_DATA-1:0]           o_mem_addr,
    output logic [NB_DATA-1:0]           o_mem_data,
    output logic [NB_CONTROL_MA_WB-1:0]  o_control_ma_wb,
    output logic [NB_ADDR_REGISTERS-1:0] o_rd_num,
    output logic                         o_stall
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;

    logic [NB_DATA-1:0]           w_rs_fwd;
    logic [NB_DATA-1:0]           w_rt_fwd;
    logic [NB_DATA-1:0]           w_op_a;
    logic [NB_DATA-1:0]           w_op_b;
    logic [4:0]                   w_shamt;
    logic [NB_DATA-1:0]           w_alu_result;

    // Multi-cycle unit view seen by the output register.
    logic                         w_stall;
    logic                         w_done;
    logic [NB_DATA-1:0]           w_md_result;
    logic [NB_DATA-1:0]           w_md_rt;
    logic [NB_CONTROL_MA_WB-1:0]  w_md_ctl;
    logic [NB_ADDR_REGISTERS-1:0] w_md_rd;

    // Forwarding mux for rs: the younger MA result beats WB; r0 never forwards.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_rs_fwd = i_rs_data;
        if (i_ma_ctl_reg_write && (i_ma_rd_num != '0) && (i_ma_rd_num == i_rs_num))
            w_rs_fwd = i_ma_rd_data;
        else if (i_wb_ctl_reg_write && (i_wb_rd_num != '0) && (i_wb_rd_num == i_rs_num))
            w_rs_fwd = i_wb_rd_data;
    end

    // Forwarding mux for rt, same priority as rs.
    always_comb begin
        w_rt_fwd = i_rt_data;
        if (i_ma_ctl_reg_write && (i_ma_rd_num != '0) && (i_ma_rd_num == i_rt_num))
            w_rt_fwd = i_ma_rd_data;
        else if (i_wb_ctl_reg_write && (i_wb_rd_num != '0) && (i_wb_rd_num == i_rt_num))
            w_rt_fwd = i_wb_rd_data;
    end

    assign w_op_a  = w_rs_fwd;
    assign w_op_b  = i_alu_src ? i_imm : w_rt_fwd;
    assign w_shamt = w_op_a[4:0];

    // Single-cycle ALU; multi-cycle opcodes and the unused codes yield 0 here.
    always_comb begin
        w_alu_result = '0;
        case (i_alu_op)
            OP_ADD:  w_alu_result = w_op_a + w_op_b;
            OP_SUB:  w_alu_result = w_op_a - w_op_b;
            OP_AND:  w_alu_result = w_op_a & w_op_b;
            OP_OR:   w_alu_result = w_op_a | w_op_b;
            OP_XOR:  w_alu_result = w_op_a ^ w_op_b;
            OP_NOR:  w_alu_result = ~(w_op_a | w_op_b);
            OP_SLT:  w_alu_result = {{(NB_DATA-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            OP_SLTU: w_alu_result = {{(NB_DATA-1){1'b0}}, (w_op_a < w_op_b)};
            OP_SLL:  w_alu_result = w_op_b << w_shamt;
            OP_SRL:  w_alu_result = w_op_b >> w_shamt;
            OP_SRA:  w_alu_result = $signed(w_op_b) >>> w_shamt;
            OP_LUI:  w_alu_result = w_op_b << 16;
            default: w_alu_result = '0;
        endcase
    end

`ifdef EXECUTE_MULDIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [4:0]                   r_count;
    logic                         r_is_div;
    logic [NB_DATA-1:0]           r_md_a;    // multiplicand / quotient-dividend shifter
    logic [NB_DATA-1:0]           r_md_b;    // multiplier shifter / divisor
    logic [NB_DATA-1:0]           r_md_acc;  // product accumulator / partial remainder
    logic [NB_DATA-1:0]           r_md_rt;
    logic [NB_CONTROL_MA_WB-1:0]  r_md_ctl;
    logic [NB_ADDR_REGISTERS-1:0] r_md_rd;
    logic                         w_md_start;
    logic [NB_DATA:0]             w_div_rem_shift;
    logic                         w_div_ge;
    logic [NB_DATA-1:0]           w_div_diff;

    assign w_md_start = i_valid && ((i_alu_op == OP_MUL) || (i_alu_op == OP_DIVU));

    // Restoring-divide step: shift in the next dividend bit, subtract if it fits.
    // A zero divisor always "fits", so the quotient saturates to all ones.
    assign w_div_rem_shift = {r_md_acc, r_md_a[NB_DATA-1]};
    assign w_div_ge        = (w_div_rem_shift >= {1'b0, r_md_b});
    assign w_div_diff      = w_div_rem_shift[NB_DATA-1:0] - r_md_b;

    // FSM state register; only pipeline-advance cycles move the machine.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= ST_IDLE;
        else if (i_clk_en)
            r_state <= w_state_next;
    end

    // FSM next state and stall request.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_md_start) begin
                    w_stall      = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (r_count == 5'd31)
                    w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand latch and one multiply/divide iteration per enabled BUSY cycle.
    // NOTE: these working registers are cleared on reset so an aborted operation leaves no residue.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_md_a   <= '0;
            r_md_b   <= '0;
            r_md_acc <= '0;
            r_md_rt  <= '0;
            r_md_ctl <= '0;
            r_md_rd  <= '0;
        end else if (i_clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_md_start) begin
                        r_count  <= '0;
                        r_is_div <= (i_alu_op == OP_DIVU);
                        r_md_a   <= w_op_a;
                        r_md_b   <= w_op_b;
                        r_md_acc <= '0;
                        r_md_rt  <= w_rt_fwd;
                        r_md_ctl <= i_control_ma_wb;
                        r_md_rd  <= i_rd_num;
                    end
                end
                ST_BUSY: begin
                    r_count <= r_count + 5'd1;
                    if (r_is_div) begin
                        r_md_a   <= {r_md_a[NB_DATA-2:0], w_div_ge};
                        r_md_acc <= w_div_ge ? w_div_diff : w_div_rem_shift[NB_DATA-1:0];
                    end else begin
                        if (r_md_b[0])
                            r_md_acc <= r_md_acc + r_md_a;
                        r_md_a <= r_md_a << 1;
                        r_md_b <= r_md_b >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_md_result = r_is_div ? r_md_a : r_md_acc;
    assign w_md_rt     = r_md_rt;
    assign w_md_ctl    = r_md_ctl;
    assign w_md_rd     = r_md_rd;
    assign o_stall     = w_stall & ~i_reset;
`else
    assign w_stall     = 1'b0;
    assign w_done      = 1'b0;
    assign w_md_result = '0;
    assign w_md_rt     = '0;
    assign w_md_ctl    = '0;
    assign w_md_rd     = '0;
    assign o_stall     = 1'b0;
`endif

    // EX/MA output register: bubbles while stalled or invalid, multi-cycle result in DONE.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_mem_addr      <= '0;
            o_mem_data      <= '0;
            o_control_ma_wb <= '0;
            o_rd_num        <= '0;
        end else if (i_clk_en) begin
            if (w_done) begin
                o_mem_addr      <= w_md_result;
                o_mem_data      <= w_md_rt;
                o_control_ma_wb <= w_md_ctl;
                o_rd_num        <= w_md_rd;
            end else begin
                o_mem_addr      <= w_alu_result;
                o_mem_data      <= w_rt_fwd;
                o_control_ma_wb <= (i_valid && !w_stall) ? i_control_ma_wb : '0;
                o_rd_num        <= i_rd_num;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
// Scoreboard bench for execute_stage: expected EX/MA bundles are queued when
// an instruction is driven and popped after the capturing edge.  Multi-cycle
// scenarios run when EXECUTE_MULDIV_EN is defined; otherwise the bench checks
// that ops 12/13 complete in one cycle with result 0 and no stall.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_execute_stage;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_clk_en;
    logic        i_valid;
    logic [31:0] i_rs_data, i_rt_data, i_imm;
    logic [4:0]  i_rs_num, i_rt_num, i_rd_num;
    logic [3:0]  i_alu_op;
    logic        i_alu_src;
    logic [6:0]  i_control_ma_wb;
    logic [4:0]  i_ma_rd_num;
    logic        i_ma_ctl_reg_write;
    logic [31:0] i_ma_rd_data;
    logic [4:0]  i_wb_rd_num;
    logic        i_wb_ctl_reg_write;
    logic [31:0] i_wb_rd_data;
    logic [31:0] o_mem_addr, o_mem_data;
    logic [6:0]  o_control_ma_wb;
    logic [4:0]  o_rd_num;
    logic        o_stall;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [6:0]  ctl;
        logic [4:0]  rd;
    } out_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } alu_vec_t;

    out_t exp_q[$];
    out_t got;
    out_t exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    assign got = {o_mem_addr, o_mem_data, o_control_ma_wb, o_rd_num};

    always #5 i_clk = ~i_clk;

    execute_stage dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_clk_en           (i_clk_en),
        .i_valid            (i_valid),
        .i_rs_data          (i_rs_data),
        .i_rt_data          (i_rt_data),
        .i_imm              (i_imm),
        .i_rs_num           (i_rs_num),
        .i_rt_num           (i_rt_num),
        .i_rd_num           (i_rd_num),
        .i_alu_op           (i_alu_op),
        .i_alu_src          (i_alu_src),
        .i_control_ma_wb    (i_control_ma_wb),
        .i_ma_rd_num        (i_ma_rd_num),
        .i_ma_ctl_reg_write (i_ma_ctl_reg_write),
        .i_ma_rd_data       (i_ma_rd_data),
        .i_wb_rd_num        (i_wb_rd_num),
        .i_wb_ctl_reg_write (i_wb_ctl_reg_write),
        .i_wb_rd_data       (i_wb_rd_data),
        .o_mem_addr         (o_mem_addr),
        .o_mem_data         (o_mem_data),
        .o_control_ma_wb    (o_control_ma_wb),
        .o_rd_num           (o_rd_num),
        .o_stall            (o_stall)
    );

    task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [6:0] ctl, input logic [4:0] rd);
        i_valid            = 1'b1;
        i_alu_op           = op;
        i_rs_num           = 5'd1;
        i_rt_num           = 5'd2;
        i_rs_data          = a;
        i_rt_data          = b;
        i_imm              = 32'h0;
        i_alu_src          = 1'b0;
        i_control_ma_wb    = ctl;
        i_rd_num           = rd;
        i_ma_rd_num        = 5'd0;
        i_ma_ctl_reg_write = 1'b0;
        i_ma_rd_data       = 32'h0;
        i_wb_rd_num        = 5'd0;
        i_wb_ctl_reg_write = 1'b0;
        i_wb_rd_data       = 32'h0;
    endtask

    task automatic test_reset();
        set_alu(4'd0, 32'd5, 32'd7, 7'h01, 5'd3);
        i_clk_en = 1'b0;
        i_reset  = 1'b1;
        @(posedge i_clk); #1;
        exp = '0;
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%h data=%h ctl=%b rd=%0d, expected all zero",
                     got.addr, got.data, got.ctl, got.rd);
        end
        n_tests++;
        if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b, expected 0", o_stall);
        end
        i_reset  = 1'b0;
        i_clk_en = 1'b1;
        i_valid  = 1'b0;
    endtask

    task automatic test_alu();
        alu_vec_t vecs [0:17];
        vecs = '{
            {4'd0,  32'd5,        32'd7,        32'd12},
            {4'd0,  32'hFFFFFFFF, 32'd1,        32'd0},
            {4'd1,  32'd3,        32'd5,        32'hFFFFFFFE},
            {4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000},
            {4'd3,  32'hF0F0F0F0, 32'h0F0000FF, 32'hFFF0F0FF},
            {4'd4,  32'hFFFF0000, 32'hF0F0F0F0, 32'h0F0FF0F0},
            {4'd5,  32'h0F0F0F0F, 32'h00F000F0, 32'hF000F000},
            {4'd6,  32'hFFFFFFFF, 32'd1,        32'd1},
            {4'd6,  32'd1,        32'hFFFFFFFF, 32'd0},
            {4'd7,  32'hFFFFFFFF, 32'd1,        32'd0},
            {4'd7,  32'd1,        32'hFFFFFFFF, 32'd1},
            {4'd8,  32'd4,        32'd1,        32'd16},
            {4'd8,  32'h24,       32'd3,        32'h30},
            {4'd9,  32'd4,        32'h80000000, 32'h08000000},
            {4'd10, 32'd4,        32'h80000000, 32'hF8000000},
            {4'd11, 32'h0000FFFF, 32'h00001234, 32'h12340000},
            {4'd14, 32'd5,        32'd7,        32'd0},
            {4'd15, 32'd5,        32'd7,        32'd0}
        };
        // Issued back to back: one instruction per enabled edge.
        for (int i = 0; i < 18; i++) begin
            set_alu(vecs[i].op, vecs[i].a, vecs[i].b, 7'h01, 5'(i + 1));
            exp_q.push_back('{addr: vecs[i].res, data: vecs[i].b, ctl: 7'h01, rd: 5'(i + 1)});
            @(posedge i_clk); #1;
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL alu[%0d] op=%0d: got addr=%h data=%h ctl=%b rd=%0d, expected addr=%h data=%h ctl=%b rd=%0d",
                         i, vecs[i].op, got.addr, got.data, got.ctl, got.rd,
                         exp.addr, exp.data, exp.ctl, exp.rd);
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic test_forwarding();
        // rs, rs_data, rt, rt_data, ma rd/w/data, wb rd/w/data, expected addr, expected store data
        logic [4:0]  rs  [0:6] = '{5'd4, 5'd4, 5'd0, 5'd4, 5'd1, 5'd1, 5'd3};
        logic [31:0] rsd [0:6] = '{32'h0, 32'h0, 32'h0, 32'h5, 32'h1, 32'h1, 32'h1};
        logic [4:0]  rt  [0:6] = '{5'd9, 5'd9, 5'd9, 5'd9, 5'd7, 5'd7, 5'd3};
        logic [31:0] rtd [0:6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h2, 32'h2, 32'h2};
        logic [4:0]  mrd [0:6] = '{5'd4, 5'd4, 5'd0, 5'd4, 5'd7, 5'd8, 5'd3};
        logic        mw  [0:6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] md  [0:6] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h30, 32'h30, 32'h100};
        logic [4:0]  wrd [0:6] = '{5'd4, 5'd4, 5'd0, 5'd4, 5'd7, 5'd7, 5'd3};
        logic        ww  [0:6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] wd  [0:6] = '{32'h20, 32'h20, 32'h20, 32'h20, 32'h40, 32'h40, 32'h200};
        logic [31:0] ea  [0:6] = '{32'h10, 32'h20, 32'h0, 32'h5, 32'h31, 32'h41, 32'h200};
        logic [31:0] ed  [0:6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h30, 32'h40, 32'h100};
        for (int i = 0; i < 7; i++) begin
            set_alu(4'd0, rsd[i], rtd[i], 7'h01, 5'd10);
            i_rs_num           = rs[i];
            i_rt_num           = rt[i];
            i_ma_rd_num        = mrd[i];
            i_ma_ctl_reg_write = mw[i];
            i_ma_rd_data       = md[i];
            i_wb_rd_num        = wrd[i];
            i_wb_ctl_reg_write = ww[i];
            i_wb_rd_data       = wd[i];
            exp_q.push_back('{addr: ea[i], data: ed[i], ctl: 7'h01, rd: 5'd10});
            @(posedge i_clk); #1;
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL fwd[%0d]: got addr=%h data=%h, expected addr=%h data=%h",
                         i, got.addr, got.data, exp.addr, exp.data);
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic test_store();
        set_alu(4'd0, 32'h100, 32'h1, 7'b0100000, 5'd0);
        i_alu_src          = 1'b1;
        i_imm              = 32'd8;
        i_rt_num           = 5'd6;
        i_wb_rd_num        = 5'd6;
        i_wb_ctl_reg_write = 1'b1;
        i_wb_rd_data       = 32'hDEAD;
        exp_q.push_back('{addr: 32'h108, data: 32'hDEAD, ctl: 7'b0100000, rd: 5'd0});
        @(posedge i_clk); #1;
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL store: got addr=%h data=%h ctl=%b, expected addr=%h data=%h ctl=%b",
                     got.addr, got.data, got.ctl, exp.addr, exp.data, exp.ctl);
        end
        i_valid = 1'b0;
    endtask

    task automatic test_bubble_and_hold();
        set_alu(4'd0, 32'd5, 32'd7, 7'h01, 5'd3);
        i_valid = 1'b0;
        exp_q.push_back('{addr: 32'd12, data: 32'd7, ctl: 7'h00, rd: 5'd3});
        @(posedge i_clk); #1;
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL bubble: got addr=%h ctl=%b rd=%0d, expected addr=%h ctl=%b rd=%0d",
                     got.addr, got.ctl, got.rd, exp.addr, exp.ctl, exp.rd);
        end
        set_alu(4'd0, 32'd1, 32'd1, 7'h41, 5'd4);
        exp_q.push_back('{addr: 32'd2, data: 32'd1, ctl: 7'h41, rd: 5'd4});
        @(posedge i_clk); #1;
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL load_enabled: got addr=%h ctl=%b rd=%0d, expected addr=%h ctl=%b rd=%0d",
                     got.addr, got.ctl, got.rd, exp.addr, exp.ctl, exp.rd);
        end
        // Disabled edges must leave the previous bundle in place.
        i_clk_en = 1'b0;
        set_alu(4'd0, 32'd9, 32'd9, 7'h01, 5'd9);
        exp_q.push_back('{addr: 32'd2, data: 32'd1, ctl: 7'h41, rd: 5'd4});
        repeat (2) @(posedge i_clk);
        #1;
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL hold_disabled: got addr=%h ctl=%b rd=%0d, expected addr=%h ctl=%b rd=%0d",
                     got.addr, got.ctl, got.rd, exp.addr, exp.ctl, exp.rd);
        end
        i_clk_en = 1'b1;
        i_valid  = 1'b0;
    endtask

`ifdef EXECUTE_MULDIV_EN
    // Presents one multi-cycle op and follows it to completion; optionally
    // drops i_clk_en for gap_len cycles starting at cycle gap_at.
    task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic [6:0] ctl,
                          input logic [4:0] rd, input int gap_at, input int gap_len);
        int   stall_cycles = 0;
        int   bubble_err   = 0;
        int   cyc          = 0;
        bit   done         = 1'b0;
        logic was_stall;
        set_alu(op, a, b, ctl, rd);
        exp_q.push_back('{addr: res, data: b, ctl: ctl, rd: rd});
        #1;
        n_tests++;
        if (o_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL %s stall_comb: got %b, expected 1", name, o_stall);
        end
        while (!done && cyc < 100) begin
            i_clk_en  = (cyc >= gap_at && cyc < gap_at + gap_len) ? 1'b0 : 1'b1;
            if (cyc == 3) begin
                // Late forwarding/regfile changes must not disturb the latched operands.
                i_ma_rd_num        = 5'd1;
                i_ma_ctl_reg_write = 1'b1;
                i_ma_rd_data       = 32'hBAD0BAD0;
                i_rt_data          = ~b;
            end
            was_stall = o_stall;
            if (was_stall === 1'b1) stall_cycles++;
            @(posedge i_clk); #1;
            if (was_stall === 1'b1) begin
                if (o_control_ma_wb !== 7'h00) bubble_err++;
            end else if (i_clk_en) begin
                done = 1'b1;
            end
            cyc++;
        end
        i_clk_en = 1'b1;
        i_valid  = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: got no completion in %0d cycles, expected completion", name, cyc);
        end
        n_tests++;
        if (stall_cycles != 33 + gap_len) begin
            n_fail++;
            $display("FAIL %s stall_len: got %0d, expected %0d", name, stall_cycles, 33 + gap_len);
        end
        n_tests++;
        if (bubble_err != 0) begin
            n_fail++;
            $display("FAIL %s bubbles: got %0d non-zero control cycles, expected 0", name, bubble_err);
        end
        exp = exp_q.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s result: got addr=%h data=%h ctl=%b rd=%0d, expected addr=%h data=%h ctl=%b rd=%0d",
                     name, got.addr, got.data, got.ctl, got.rd, exp.addr, exp.data, exp.ctl, exp.rd);
        end
    endtask

    task automatic test_back_to_back_muldiv();
        run_md("mul",       4'd12, 32'h00010003, 32'd5,        32'h0005000F, 7'h01, 5'd8,  -1, 0);
        run_md("divu",      4'd13, 32'd100,      32'd7,        32'd14,       7'h01, 5'd9,  -1, 0);
        run_md("divu_zero", 4'd13, 32'd5,        32'd0,        32'hFFFFFFFF, 7'h01, 5'd10, -1, 0);
        run_md("divu_big",  4'd13, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 7'h03, 5'd11, -1, 0);
    endtask

    task automatic test_enable_gap();
        run_md("mul_gap", 4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 7'h01, 5'd12, 10, 5);
    endtask

    task automatic test_reset_midbusy();
        set_alu(4'd12, 32'd7, 32'd9, 7'h01, 5'd5);
        repeat (11) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        i_valid = 1'b0;
        #1;
        n_tests++;
        if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy_stall_now: got %b, expected 0", o_stall);
        end
        @(posedge i_clk); #1;
        exp = '0;
        n_tests++;
        if (got !== exp || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy_outputs: got addr=%h data=%h ctl=%b rd=%0d stall=%b, expected all zero",
                     got.addr, got.data, got.ctl, got.rd, o_stall);
        end
        i_reset = 1'b0;
        @(posedge i_clk); #1;
        n_tests++;
        if (o_stall !== 1'b0 || o_control_ma_wb !== 7'h00) begin
            n_fail++;
            $display("FAIL rst_busy_idle: got stall=%b ctl=%b, expected stall=0 ctl=0",
                     o_stall, o_control_ma_wb);
        end
        run_md("divu_after_rst", 4'd13, 32'd100, 32'd7, 32'd14, 7'h01, 5'd13, -1, 0);
    endtask
`else
    task automatic test_no_muldiv();
        logic [3:0] ops [0:1] = '{4'd12, 4'd13};
        for (int i = 0; i < 2; i++) begin
            set_alu(ops[i], 32'd3, 32'd5, 7'h01, 5'd6);
            exp_q.push_back('{addr: 32'd0, data: 32'd5, ctl: 7'h01, rd: 5'd6});
            #1;
            n_tests++;
            if (o_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL nomd_stall op=%0d: got %b, expected 0", ops[i], o_stall);
            end
            @(posedge i_clk); #1;
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp || o_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL nomd_result op=%0d: got addr=%h ctl=%b stall=%b, expected addr=%h ctl=%b stall=0",
                         ops[i], got.addr, got.ctl, o_stall, exp.addr, exp.ctl);
            end
        end
        i_valid = 1'b0;
    endtask
`endif

    initial begin
        i_reset  = 1'b0;
        i_clk_en = 1'b1;
        set_alu(4'd0, 32'd0, 32'd0, 7'h00, 5'd0);
        i_valid = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_alu();
        test_forwarding();
        test_store();
        test_bubble_and_hold();
`ifdef EXECUTE_MULDIV_EN
        test_back_to_back_muldiv();
        test_enable_gap();
        test_reset_midbusy();
`else
        test_no_muldiv();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter NB_DATA, default 32, datapath width.
REQ-002 Parameter NB_ADDR_REGISTERS, default 5, register-number width.
REQ-003 Parameter NB_CONTROL_MA_WB, default 7, control bus forwarded to memory access: [6] mem_read, [5] mem_write, [4:3] addressing, [2] signing, [1:0] write-back ([0] = reg_write).
REQ-004 Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_clk_en  in  1  pipeline advance enable.
- i_valid  in  1  instruction in EX is real, not a bubble.
- i_rs_data, i_rt_data  in  NB_DATA  register-file read data.
- i_imm  in  NB_DATA  sign-extended immediate.
- i_rs_num, i_rt_num, i_rd_num  in  NB_ADDR_REGISTERS  source and destination numbers.
- i_alu_op  in  4  operation code.
- i_alu_src  in  1  1 = operand B is i_imm.
- i_control_ma_wb  in  NB_CONTROL_MA_WB  control bus.
- i_ma_rd_num, i_ma_ctl_reg_write, i_ma_rd_data  in  5/1/NB_DATA  memory-access forwarding source.
- i_wb_rd_num, i_wb_ctl_reg_write, i_wb_rd_data  in  5/1/NB_DATA  write-back forwarding source.
- o_mem_addr  out  NB_DATA  registered ALU result.
- o_mem_data  out  NB_DATA  registered forwarded rt value (store data).
- o_control_ma_wb  out  NB_CONTROL_MA_WB  registered control bus.
- o_rd_num  out  NB_ADDR_REGISTERS  registered destination.
- o_stall  out  1  upstream must hold its EX inputs.

Function
REQ-005 Forwarding per operand: MA match (reg_write=1, rd_num≠0, rd_num==src) wins over WB match under the same rule; otherwise register-file data.
REQ-006 Operand A = forwarded rs. Operand B = i_imm if i_alu_src=1, else forwarded rt. o_mem_data always takes forwarded rt.
REQ-007 Single-cycle ops, mod 2^NB_DATA:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
- 6 SLT signed, 7 SLTU: result 1 or 0.
- 8 SLL, 9 SRL, 10 SRA: shift B by A[4:0].
- 11 LUI: B<<16.
- 14, 15: result 0.
REQ-008 Multi-cycle ops: 12 MUL (low NB_DATA bits, unsigned shift-add); 13 DIVU (quotient, restoring). Divide by zero yields all ones.
REQ-009 Output register loads on each i_clk_en edge and holds otherwise. i_valid=0 loads control 0.
REQ-010 FSM IDLE/BUSY/DONE advances only when i_clk_en=1.
REQ-011 IDLE: if i_valid and op is 12 or 13, o_stall=1 combinationally; operands are latched; counter clears; next state BUSY.
REQ-012 BUSY: one iteration per enabled cycle; o_stall=1; after 32 iterations (count 31), next state DONE.
REQ-013 DONE: o_stall=0; output register captures the result with the latched control and rd; next state IDLE.
REQ-014 While o_stall=1, the output register loads control 0, so memory access sees bubbles. Stall lasts 33 enabled cycles; the result appears on the 34th enabled edge.
REQ-015 Forwarding inputs are ignored after latching; changes during BUSY have no effect.
REQ-016 A back-to-back multi-cycle op presented in DONE is accepted on the following IDLE cycle.

Reset
REQ-017 On i_reset, all outputs, the FSM (IDLE), the counter and the latched operands clear to 0 on the next edge; o_stall=0 in that cycle. Reset overrides i_clk_en and aborts any BUSY operation without output.

Configuration
REQ-018 Macro EXECUTE_MULDIV_EN defined: REQ-008, REQ-010 to REQ-016 apply. Macro undefined: no FSM or counter; ops 12 and 13 give result 0 in one cycle; o_stall is tied 0.

Verification
REQ-019 ADD A=5 B=7, control 7'b0000001, rd=3 -> next enabled edge: o_mem_addr=12, o_rd_num=3, o_control_ma_wb=7'b0000001.
REQ-020 rs=4, rs_data=0, MA rd=4 write=1 data=0x10, WB rd=4 write=1 data=0x20 -> A=0x10. MA write=0 -> A=0x20. rs=0 with rd=0 on both sources -> A=0.
REQ-021 Store: alu_src=1, imm=8, rs_data=0x100, rt forwarded from WB 0xDEAD -> o_mem_addr=0x108, o_mem_data=0xDEAD. SRA 0x80000000 by 4 -> 0xF8000000.
REQ-022 MUL 0x00010003*5 -> o_stall high 33 cycles, control output 0 throughout, then o_mem_addr=0x0005000F. DIVU 100/7 -> 14. DIVU 5/0 -> 0xFFFFFFFF.
REQ-023 Reset at BUSY count 10 -> next edge: o_stall=0, all outputs 0, FSM IDLE. i_clk_en=0 for 5 cycles mid-BUSY -> stall extends by exactly 5 cycles.
REQ-024 Build without EXECUTE_MULDIV_EN, MUL 3*5 -> o_stall stays 0, o_mem_addr=0 after one cycle.
